noc_output_arbiter: RTL and testbench
=====================================

# noc_output_arbiter

Round-robin arbiter and single-entry output register for one router output port of the mesh node. It shares one output link among the node's five input sources (local core plus North, East, South, West), one flit per transfer. It drives the port's dout/vout and obeys the downstream rin ready signal. Each node instantiates one arbiter per output direction; the mesh-level valid/ready wiring is unchanged.

## Interface
- NUM_IN, 5, number of requesters; index 0 = local, 1 = North, 2 = East, 3 = South, 4 = West (matches node port numbering).
- DATA_WIDTH, 32, flit width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  NUM_IN*DATA_WIDTH  flit from requester i, occupying slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_IN  requester i holds a flit.
- req_ready  out  NUM_IN  one-hot or zero; requester i's flit is consumed this cycle.
- dout  out  DATA_WIDTH  registered output flit.
- vout  out  1  dout is valid.
- rin  in  1  downstream is ready; a transfer occurs when vout && rin.

## Operation
- Output stage: one-entry register holding dout plus a valid bit (vout).
- can_accept = !vout || rin. The register is empty, or is being drained this cycle.
- Grant selection is combinational every cycle and is not locked across cycles:
  - Scan req_valid starting at index ptr, wrapping modulo NUM_IN.
  - The first set bit is the winner g.
- req_ready[g] = can_accept && |req_valid. All other req_ready bits are 0.
- Accept (req_valid[g] && req_ready[g]):
  - dout <= req_data slice g.
  - vout <= 1.
  - ptr <= (g == NUM_IN-1) ? 0 : g+1.
- Drain without accept (vout && rin, no request): vout <= 0; dout holds its value.
- No accept: ptr holds.
- Fairness: a continuously valid requester is granted within NUM_IN accepted transfers.
- Requesters must hold valid and data stable until ready. If a requester drops valid early, the arbiter simply re-arbitrates; no error is flagged.
- rin low with vout high: register holds, all req_ready = 0, ptr holds.

## Timing
- Reset values: vout=0, dout=0, ptr=0, req_ready=0 (req_ready is forced 0 while rst is high). Statistic counters are 0.
- Latency: a flit accepted in cycle N appears on dout/vout in cycle N+1.
- Throughput: one flit per cycle while rin=1, including a simultaneous drain and accept in the same cycle.
- req_ready depends combinationally on req_valid, ptr, vout and rin. There is no combinational path from req_data to any output.
- Reset mid-operation: the buffered flit is discarded (vout=0 on the next cycle) and ptr returns to 0. Requesters see no ready during reset.
- Wrap-around: a grant to index NUM_IN-1 sets ptr to 0.

## Configuration
- NOC_ARB_STATS_EN defined:
  - Adds output stat_grants (NUM_IN*16), one 16-bit saturating counter per requester, incremented on each of its accepts.
  - Adds output stat_stall (16), a saturating count of cycles with vout && !rin.
  - Counters saturate at 16'hFFFF and clear on rst.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package noc_pkg:
  - Port index constants PORT_LOCAL=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4.
  - Default DATA_WIDTH=32.
  - Statistics counter width STAT_W=16.
- Sub-module rr_arbiter (NUM_IN):
  - Contains the rotating-priority grant logic and the ptr register.
  - Inputs: req, advance.
  - Outputs: grant one-hot, grant index.
  - ptr is updated only when advance is high.
- The top level owns the output register, the handshake logic and the optional statistics.

## Test plan
- Reset, then only req_valid=5'b00100 with data 0xA5 and rin=1 → req_ready=5'b00100 in cycle 0; dout=0xA5 and vout=1 in cycle 1; ptr=3.
- All five valid continuously, rin=1, from reset → grant order 0,1,2,3,4,0 on consecutive cycles, one flit per cycle.
- rin=0 with vout=1 for 4 cycles, all requesters valid → req_ready=0 and dout stable; when rin rises, the next grant follows the stored ptr with no skipped requester.
- ptr=4, req_valid=5'b10001 → grant 4, then 0 (wrap-around), then 4.
- rst asserted while vout=1 and rin=0 → next cycle vout=0, dout=0, ptr=0; the first grant after release goes to the lowest-index valid requester.
- With NOC_ARB_STATS_EN: requester 1 granted 3 times and 2 stall cycles → stat_grants[1]=3, stat_stall=2. Preload near 16'hFFFF → counter saturates rather than wrapping.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants for the mesh router: port numbering, default flit width, statistics counter width.
package noc_pkg;

    localparam int PORT_LOCAL     = 0;
    localparam int PORT_N         = 1;
    localparam int PORT_E         = 2;
    localparam int PORT_S         = 3;
    localparam int PORT_W         = 4;
    localparam int NUM_PORTS      = PORT_W + 1;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int STAT_W         = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: scans req from ptr with wrap-around; ptr moves past the winner on advance.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN = NUM_PORTS,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Priority restarts just after the last winner, which bounds every requester's wait to NUM_IN grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output port of a mesh router: round-robin over NUM_IN sources into a one-entry output register.
// Optional per-requester grant and stall counters are built when NOC_ARB_STATS_EN is defined.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN     = NUM_PORTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_IN-1:0]            req_valid,
    output logic [NUM_IN-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         vout,
    input  logic                         rin
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [NUM_IN*STAT_W-1:0]     stat_grants,
    output logic [STAT_W-1:0]            stat_stall
`endif
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              can_accept;
    logic              accept;

    assign can_accept = !vout || rin;
    assign req_ready  = (rst || !can_accept || !(|req_valid)) ? '0 : grant;
    assign accept     = |req_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accepting while the old flit drains keeps the link at one flit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (accept) begin
            vout <= 1'b1;
            dout <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (rin) begin
            vout <= 1'b0;
        end
    end

`ifdef NOC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (req_ready[i] && stat_grants[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}) begin
                    stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if (vout && !rin && stat_stall != {STAT_W{1'b1}}) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Randomized self-checking bench for noc_output_arbiter against a cycle-level reference model.
// Statistics ports are checked as well when NOC_ARB_STATS_EN is defined.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   dout;
    logic            vout;
    logic            rin;
`ifdef NOC_ARB_STATS_EN
    logic [N*STAT_W-1:0] stat_grants;
    logic [STAT_W-1:0]   stat_stall;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: pointer, output register, statistics
    int          m_ptr = 0;
    logic        m_vout = 1'b0;
    logic [31:0] m_dout = '0;
    int          m_grants[N];
    int          m_stall = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .dout      (dout),
        .vout      (vout),
        .rin       (rin)
`ifdef NOC_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check ready, advance the model, check the registered output.
    task automatic applyStimulus(input logic [N-1:0] v, input logic r_in, input logic r_st);
        logic [31:0] d[N];
        logic [31:0] exp_ready;
        int          w;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            d[i] = $urandom;
            req_data[i*DW +: DW] = d[i];
        end
        req_valid = v;
        rin       = r_in;
        rst       = r_st;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (!r_st && w >= 0 && (!m_vout || r_in)) exp_ready[w] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), exp_ready);
        if (r_st) begin
            m_vout = 1'b0;
            m_dout = '0;
            m_ptr  = 0;
            m_stall = 0;
            for (int i = 0; i < N; i++) m_grants[i] = 0;
        end else begin
            if (m_vout && !r_in) m_stall++;
            if (exp_ready != 0) begin
                m_dout = d[w];
                m_vout = 1'b1;
                m_ptr  = (w + 1) % N;
                m_grants[w]++;
            end else if (m_vout && r_in) begin
                m_vout = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("vout", 32'(vout), 32'(m_vout));
        checkOutput("dout", dout, m_dout);
    endtask

    initial begin
        rst = 1'b1; rin = 1'b0; req_valid = '0; req_data = '0;
        for (int i = 0; i < N; i++) m_grants[i] = 0;
        applyStimulus(5'b00000, 1'b0, 1'b1);
        applyStimulus(5'b11111, 1'b1, 1'b1);

        // Single requester 2, then ptr sits at 3 so 2 and 3 compete: 3 must win
        applyStimulus(5'b00100, 1'b1, 1'b0);
        applyStimulus(5'b01100, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b1, 1'b0);

        // Full load from reset: 0,1,2,3,4,0
        applyStimulus(5'b00000, 1'b1, 1'b1);
        repeat (6) applyStimulus(5'b11111, 1'b1, 1'b0);

        // Backpressure for four cycles, then resume
        repeat (4) applyStimulus(5'b11111, 1'b0, 1'b0);
        repeat (3) applyStimulus(5'b11111, 1'b1, 1'b0);

        // Wrap-around between 4 and 0
        applyStimulus(5'b00000, 1'b1, 1'b1);
        applyStimulus(5'b01000, 1'b1, 1'b0);
        repeat (3) applyStimulus(5'b10001, 1'b1, 1'b0);

        // Reset while holding a stalled flit
        applyStimulus(5'b11111, 1'b1, 1'b0);
        applyStimulus(5'b11111, 1'b0, 1'b1);
        applyStimulus(5'b10110, 1'b1, 1'b0);

        // Stats-friendly directed segment: requester 1 granted 3 times, 2 stall cycles
        applyStimulus(5'b00000, 1'b1, 1'b1);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        applyStimulus(5'b00010, 1'b0, 1'b0);
        applyStimulus(5'b00010, 1'b0, 1'b0);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b1, 1'b0);
`ifdef NOC_ARB_STATS_EN
        checkOutput("stat_grants1", 32'(stat_grants[1*STAT_W +: STAT_W]), 32'd3);
        checkOutput("stat_stall", 32'(stat_stall), 32'd2);
`endif

        for (int n = 0; n < 400; n++) begin
            applyStimulus(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end

`ifdef NOC_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checkOutput("stat_grants", 32'(stat_grants[i*STAT_W +: STAT_W]), 32'(m_grants[i]));
        end
        checkOutput("stat_stall_rand", 32'(stat_stall), 32'(m_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
